// File: rtl/frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// frame_write_arbiter
//
// N-channel write arbiter for frame buffer port A. Clients request single
// writes or locked bursts; one write per cycle is forwarded to the frame
// buffer through registered outputs, with a per-channel req/gnt handshake.
//
// Parameters
//   NUM_CH  number of client channels (>= 1)
//   ADDR_W  frame buffer address width
//   DATA_W  pixel width
//
// Ports
//   clk      in   system clock, sole clock
//   rst      in   synchronous active-high reset
//   req      in   [NUM_CH]         per-channel write request, held until granted
//   lock     in   [NUM_CH]         per-channel burst lock, keeps ownership while high
//   ch_addr  in   [NUM_CH*ADDR_W]  flat addresses, ch i = [i*ADDR_W +: ADDR_W]
//   ch_data  in   [NUM_CH*DATA_W]  flat data, ch i = [i*DATA_W +: DATA_W]
//   gnt      out  [NUM_CH]         registered one-hot (or zero) grant
//   fb_we    out                   registered frame buffer write enable
//   fb_addr  out  [ADDR_W]         registered frame buffer address
//   fb_data  out  [DATA_W]         registered frame buffer data
//   idle     out                   high when no owner and gnt == 0
//
// Build option
//   FRAME_WR_ARB_RR_EN  defined: round-robin search starting at a rotating
//                       pointer; undefined: fixed priority, lowest index wins.
// ---------------------------------------------------------------------------
module frame_write_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        lock,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        gnt,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [DATA_W-1:0]        fb_data,
    output logic                     idle
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Channel index to one-hot vector; loop form keeps indices in range for any NUM_CH
    function automatic logic [NUM_CH-1:0] to_onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            oh[i] = (CH_W'(i) == idx);
        end
        return oh;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CH_W-1:0]     owner_r;
    logic [CH_W-1:0]     owner_nxt_s;
    logic [NUM_CH-1:0]   gnt_r;
    logic [NUM_CH-1:0]   gnt_nxt_s;
    logic                idle_r;
    logic                idle_nxt_s;
    logic                fb_we_r;
    logic [ADDR_W-1:0]   fb_addr_r;
    logic [DATA_W-1:0]   fb_data_r;

    logic                win_found_s;
    logic [CH_W-1:0]     win_idx_s;
    logic                win_lock_s;
    logic                owner_lock_s;
    state_t              arb_state_s;
    logic [CH_W-1:0]     arb_owner_s;
    logic [NUM_CH-1:0]   arb_gnt_s;

    logic                acc_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_data_s;

`ifdef FRAME_WR_ARB_RR_EN
    logic [CH_W-1:0]     rr_ptr_r;
    logic [CH_W-1:0]     rr_ptr_nxt_s;
    logic                arb_taken_s;
`endif

    // Winner search over current requesters (rotating start or fixed order)
    always_comb begin
        logic hit;
`ifdef FRAME_WR_ARB_RR_EN
        int   cand;
`endif
        win_found_s = 1'b0;
        win_idx_s   = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef FRAME_WR_ARB_RR_EN
            cand        = int'(rr_ptr_r) + k;
            cand        = (cand >= NUM_CH) ? (cand - NUM_CH) : cand;
            hit         = ~win_found_s & (|(req & to_onehot(CH_W'(cand))));
            win_idx_s   = hit ? CH_W'(cand) : win_idx_s;
`else
            hit         = ~win_found_s & req[k];
            win_idx_s   = hit ? CH_W'(k) : win_idx_s;
`endif
            win_found_s = win_found_s | hit;
        end
    end

    // Outcome of a fresh arbitration round (used from IDLE and on lock release)
    always_comb begin
        win_lock_s   = |(lock & to_onehot(win_idx_s));
        owner_lock_s = |(lock & to_onehot(owner_r));
        if (win_found_s) begin
            arb_gnt_s   = to_onehot(win_idx_s);
            arb_state_s = win_lock_s ? ST_OWNED : ST_IDLE;
            arb_owner_s = win_idx_s;
        end else begin
            arb_gnt_s   = {NUM_CH{1'b0}};
            arb_state_s = ST_IDLE;
            arb_owner_s = owner_r;
        end
    end

    // Next-state / next-grant logic: a locked owner keeps the grant, even with req low
    always_comb begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = owner_r;
        gnt_nxt_s   = {NUM_CH{1'b0}};
`ifdef FRAME_WR_ARB_RR_EN
        arb_taken_s = 1'b0;
`endif
        case (state_r)
            ST_OWNED: begin
                if (owner_lock_s) begin
                    state_nxt_s = ST_OWNED;
                    owner_nxt_s = owner_r;
                    gnt_nxt_s   = to_onehot(owner_r);
                end else begin
                    state_nxt_s = arb_state_s;
                    owner_nxt_s = arb_owner_s;
                    gnt_nxt_s   = arb_gnt_s;
`ifdef FRAME_WR_ARB_RR_EN
                    arb_taken_s = 1'b1;
`endif
                end
            end
            ST_IDLE: begin
                state_nxt_s = arb_state_s;
                owner_nxt_s = arb_owner_s;
                gnt_nxt_s   = arb_gnt_s;
`ifdef FRAME_WR_ARB_RR_EN
                arb_taken_s = 1'b1;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = {CH_W{1'b0}};
                gnt_nxt_s   = {NUM_CH{1'b0}};
            end
        endcase
        idle_nxt_s = (state_nxt_s == ST_IDLE) && (gnt_nxt_s == {NUM_CH{1'b0}});
    end

`ifdef FRAME_WR_ARB_RR_EN
    // Pointer advances past each newly granted winner; held OWNED cycles leave it alone
    always_comb begin
        if (arb_taken_s && win_found_s) begin
            rr_ptr_nxt_s = (win_idx_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                            : (win_idx_s + CH_W'(1));
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {CH_W{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end
`endif

    // Accepted write this cycle: grant is one-hot, so an OR of masked slices selects it
    always_comb begin
        acc_s      = |(req & gnt_r);
        acc_addr_s = {ADDR_W{1'b0}};
        acc_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            acc_addr_s = acc_addr_s |
                         ({ADDR_W{req[i] & gnt_r[i]}} & ch_addr[i*ADDR_W +: ADDR_W]);
            acc_data_s = acc_data_s |
                         ({DATA_W{req[i] & gnt_r[i]}} & ch_data[i*DATA_W +: DATA_W]);
        end
    end

    // Arbiter state, grant and frame buffer output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            owner_r   <= {CH_W{1'b0}};
            gnt_r     <= {NUM_CH{1'b0}};
            idle_r    <= 1'b1;
            fb_we_r   <= 1'b0;
            fb_addr_r <= {ADDR_W{1'b0}};
            fb_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            gnt_r   <= gnt_nxt_s;
            idle_r  <= idle_nxt_s;
            fb_we_r <= acc_s;
            if (acc_s) begin
                fb_addr_r <= acc_addr_s;
                fb_data_r <= acc_data_s;
            end
        end
    end

    assign gnt     = gnt_r;
    assign fb_we   = fb_we_r;
    assign fb_addr = fb_addr_r;
    assign fb_data = fb_data_r;
    assign idle    = idle_r;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_write_arbiter
//
// Self-checking bench for frame_write_arbiter: a 4-channel instance checked
// against a cycle-level reference model plus a vector table and directed
// sequences (reset, single write, locked burst, arbitration order, reset
// mid-burst, random traffic), and a 1-channel instance with its own model.
// ---------------------------------------------------------------------------
module tb_frame_write_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 17;
    localparam int DW  = 24;
`ifdef FRAME_WR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    lock;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    gnt;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [DW-1:0]     fb_data;
    logic              idle;

    logic              rst1;
    logic [0:0]        req1;
    logic [0:0]        lock1;
    logic [AW-1:0]     addr1;
    logic [DW-1:0]     data1;
    logic [0:0]        gnt1;
    logic              we1;
    logic [AW-1:0]     fbaddr1;
    logic [DW-1:0]     fbdata1;
    logic              idle1;

    always #5 clk = ~clk;

    frame_write_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .ch_addr(ch_addr), .ch_data(ch_data),
        .gnt(gnt), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .idle(idle)
    );

    frame_write_arbiter #(.NUM_CH(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .lock(lock1),
        .ch_addr(addr1), .ch_data(data1),
        .gnt(gnt1), .fb_we(we1), .fb_addr(fbaddr1), .fb_data(fbdata1), .idle(idle1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NCH-1:0] m_gnt;
    logic           m_we;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    logic           m_idle;
    int             m_owner;
    int             m_ptr;

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] lock;
        logic [NCH-1:0] gnt;
        logic           we;
        logic           idle;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_addr[i*AW +: AW] = a;
        ch_data[i*DW +: DW] = d;
    endtask

    // One clock of the arbiter rules applied to the inputs currently driven
    task automatic model_update();
        int acc;
        int w;
        int start;
        int c;
        if (rst) begin
            m_gnt = '0; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_owner = -1; m_ptr = 0; m_idle = 1'b1;
        end else begin
            acc = -1;
            for (int i = 0; i < NCH; i++) begin
                if (m_gnt[i] && req[i]) acc = i;
            end
            m_we = (acc >= 0);
            if (acc >= 0) begin
                m_addr = ch_addr[acc*AW +: AW];
                m_data = ch_data[acc*DW +: DW];
            end
            if (m_owner >= 0 && lock[m_owner]) begin
                m_gnt = 4'b0001 << m_owner;
            end else begin
                start = RR ? m_ptr : 0;
                w = -1;
                for (int k = 0; k < NCH; k++) begin
                    c = (start + k) % NCH;
                    if (w < 0 && req[c]) w = c;
                end
                if (w < 0) begin
                    m_gnt = '0;
                    m_owner = -1;
                end else begin
                    m_gnt = 4'b0001 << w;
                    m_owner = lock[w] ? w : -1;
                    m_ptr = (w + 1) % NCH;
                end
            end
            m_idle = (m_owner < 0) && (m_gnt == 4'b0000);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("model_gnt", 32'(gnt), 32'(m_gnt));
        chk("model_fb_we", 32'(fb_we), 32'(m_we));
        chk("model_fb_addr", 32'(fb_addr), 32'(m_addr));
        chk("model_fb_data", 32'(fb_data), 32'(m_data));
        chk("model_idle", 32'(idle), 32'(m_idle));
    endtask

    int beat;
    int we_cnt;
    int cyc;
    int acc1_cnt;
    int we1_cnt;
    logic       m1_g;
    logic       m1_we;
    logic       m1_acc;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_data;
    logic [NCH-1:0] exp_g;

    initial begin
        rst = 1'b1; req = 4'hF; lock = 4'h0; ch_addr = '0; ch_data = '0;
        rst1 = 1'b1; req1 = 1'b0; lock1 = 1'b0; addr1 = '0; data1 = '0;

        // Vector table: rows applied in order straight after reset
        tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 17'h00000, 24'h000000};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 17'h00123, 24'hFF0000};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 17'h00123, 24'hFF0000};
        tbl[3]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 17'h00123, 24'hFF0000};
        tbl[4]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 17'h00123, 24'hFF0000};
        tbl[5]  = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 17'h00B11, 24'h00BB00};
        tbl[6]  = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0, 17'h00B11, 24'h00BB00};
        tbl[7]  = '{4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b0, 17'h00B11, 24'h00BB00};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 17'h00B11, 24'h00BB00};
        tbl[9]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 17'h00A00, 24'h0000AA};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 17'h00A00, 24'h0000AA};

        // Reset held three cycles with every channel requesting
        set_ch(0, 17'h00A00, 24'h0000AA);
        set_ch(1, 17'h00B11, 24'h00BB00);
        set_ch(2, 17'h00123, 24'hFF0000);
        set_ch(3, 17'h00C33, 24'hCC0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_we", 32'(fb_we), 32'h0);
            chk("rst_addr", 32'(fb_addr), 32'h0);
            chk("rst_idle", 32'(idle), 32'h1);
        end
        rst = 1'b0;

        // Table-driven single writes, gaps and a short locked burst
        for (int r = 0; r < 11; r++) begin
            req  = tbl[r].req;
            lock = tbl[r].lock;
            step();
            chk("tbl_gnt", 32'(gnt), 32'(tbl[r].gnt));
            chk("tbl_we", 32'(fb_we), 32'(tbl[r].we));
            chk("tbl_idle", 32'(idle), 32'(tbl[r].idle));
            chk("tbl_addr", 32'(fb_addr), 32'(tbl[r].addr));
            chk("tbl_data", 32'(fb_data), 32'(tbl[r].data));
        end

        // Locked 8-beat burst on ch1, ch0 requesting throughout, gap on beat 4
        req = 4'b0010; lock = 4'b0010;
        set_ch(1, 17'h01000, 24'h100000);
        step();
        beat = 0; we_cnt = 0; cyc = 0;
        while (beat < 8 && cyc < 40) begin
            req[0] = 1'b1;
            req[1] = (cyc != 3);
            set_ch(1, 17'(17'h01000 + beat), 24'(24'h100000 + beat));
            lock[1] = !(req[1] && beat == 7);
            if (req[1] && m_gnt[1]) beat++;
            step();
            exp_g = (beat < 8) ? 4'b0010 : 4'b0001;
            chk("burst_gnt", 32'(gnt), 32'(exp_g));
            if (fb_we) begin
                chk("burst_addr_order", 32'(fb_addr), 32'(17'h01000 + we_cnt));
                we_cnt++;
            end
            cyc++;
        end
        req = 4'b0000; lock = 4'b0000;
        step();
        if (fb_we) we_cnt++;
        chk("burst_we_pulses", 32'(we_cnt), 32'd8);

        // Arbitration order from reset with all channels requesting, no lock
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'hF; lock = 4'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_g = RR ? (4'b0001 << (i % 4)) : 4'b0001;
            chk("arb_order_gnt", 32'(gnt), 32'(exp_g));
        end

        // Reset on the third beat of a ch3 locked burst
        req = 4'b1000; lock = 4'b1000;
        step();
        chk("rb_gnt_start", 32'(gnt), 32'h8);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rb_we_after_rst", 32'(fb_we), 32'h0);
        chk("rb_gnt_after_rst", 32'(gnt), 32'h0);
        rst = 1'b0;
        step();
        chk("rb_gnt_return", 32'(gnt), 32'h8);
        step();
        req = 4'b0000; lock = 4'b0000;
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            req = 4'($urandom_range(0, 15));
            for (int c = 0; c < NCH; c++) begin
                lock[c] = ($urandom_range(0, 3) == 0);
                set_ch(c, 17'($urandom), 24'($urandom));
            end
            step();
        end
        rst = 1'b0; req = '0; lock = '0;

        // Single-channel instance: toggling then random requests
        @(posedge clk); #1;
        rst1 = 1'b0;
        m1_g = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_data = '0;
        acc1_cnt = 0; we1_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            req1  = (c < 8) ? 1'((c % 2) == 0) : 1'($urandom_range(0, 1));
            addr1 = 17'(c * 5 + 1);
            data1 = 24'(c * 7 + 3);
            m1_acc = req1[0] & m1_g;
            if (m1_acc) begin
                m1_addr = addr1;
                m1_data = data1;
                acc1_cnt++;
            end
            m1_we = m1_acc;
            m1_g  = req1[0];
            @(posedge clk); #1;
            if (we1) we1_cnt++;
            chk("ch1_gnt", 32'(gnt1), 32'(m1_g));
            chk("ch1_we", 32'(we1), 32'(m1_we));
            chk("ch1_addr", 32'(fbaddr1), 32'(m1_addr));
            chk("ch1_data", 32'(fbdata1), 32'(m1_data));
        end
        chk("ch1_we_count", 32'(we1_cnt), 32'(acc1_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
